cycle_seq: RTL and testbench
============================

CYCLE_SEQ -- requirements
Module: cycle_seq

Interface
REQ-001 The block SHALL have a single clock and an asynchronous, active-high reset, with ports named clk and reset.
REQ-002 Parameter CNT_W, default 8, SHALL set the width of the executed-instruction counter.
REQ-003 clk  in  1  system clock; all state updates on its rising edge.
REQ-004 reset  in  1  asynchronous, active-high reset.
REQ-005 branch_req  in  1  from decode: the executing instruction changes the PC (GOTO/CALL/RETURN/taken skip); sampled only in Q4.
REQ-006 halt_req  in  1  request to stop at the next instruction-cycle boundary; sampled only in Q4 and while halted.
REQ-007 q1, q2, q3, q4  out  1 each  registered quadrature phase strobes, one-hot or all-zero.
REQ-008 fetch_en  out  1  load instruction register; equals q4 in FILL, RUN and FLUSH.
REQ-009 pc_inc  out  1  advance program counter; equals q1 in FILL, RUN and FLUSH.
REQ-010 exec_valid  out  1  the current instruction cycle executes a real instruction; 0 means NOP (no writeEn, no W/RAM update).
REQ-011 state  out  2  IDLE=0, FILL=1, RUN=2, HALT=3; FLUSH is reported as RUN with exec_valid=0.
REQ-012 cycle_cnt  out  CNT_W  count of completed instruction cycles with exec_valid=1.

Function
REQ-013 An instruction cycle SHALL be four consecutive clk cycles with q1, q2, q3, q4 high in that order.
REQ-014 States SHALL be IDLE, FILL, RUN, FLUSH and HALT; phases advance only in FILL, RUN and FLUSH.
REQ-015 IDLE SHALL go to FILL on the first clk edge after reset deasserts, with q1 high in that same cycle.
REQ-016 FILL SHALL be exactly one instruction cycle with exec_valid=0 (pipeline empty) and SHALL go to RUN after Q4.
REQ-017 In RUN, branch_req=1 at Q4 SHALL make the next instruction cycle FLUSH (exec_valid=0, prefetched word discarded), then return to RUN.
REQ-018 halt_req=1 at Q4 of FILL, RUN or FLUSH SHALL enter HALT after that Q4, with all strobes, fetch_en and pc_inc at 0.
REQ-019 HALT SHALL exit on the first clk edge with halt_req=0, resuming at Q1 with the pipeline contents preserved.
REQ-020 If branch_req and halt_req are both 1 at the same Q4, HALT SHALL be entered and the first cycle after exit SHALL be FLUSH.
REQ-021 branch_req in FILL or FLUSH SHALL be ignored.
REQ-022 exec_valid SHALL be constant across all four phases of an instruction cycle.
REQ-023 cycle_cnt SHALL increment at the Q4-to-Q1 boundary of each cycle with exec_valid=1, and SHALL wrap from 2^CNT_W-1 to 0.

Reset
REQ-024 Asserting reset at any time, including mid-cycle, SHALL immediately set state=IDLE, q1..q4=0, fetch_en=0, pc_inc=0, exec_valid=0, cycle_cnt=0, and clear any pending flush.

Configuration
REQ-025 With CYCLE_SEQ_STEP_EN defined, the block SHALL add input step (1 bit); in HALT, a 1-clk step pulse SHALL run exactly one instruction cycle and return to HALT, even if halt_req is still 1.
REQ-026 Without CYCLE_SEQ_STEP_EN, there SHALL be no step port and HALT SHALL exit only through halt_req=0.

Structure
REQ-027 Package cycle_seq_pkg SHALL hold the state enum, the phase enum (Q1..Q4) and the state output encodings.
REQ-028 A sub-module phase_gen (2-bit phase counter with enable, producing the one-hot strobes) SHALL be instantiated; all other logic SHALL be in cycle_seq.

Verification
REQ-029 Reset pulse, then free run for 12 clk -> q1,q2,q3,q4 repeat with period 4; exec_valid=0 for clk 1-4 and 1 thereafter; cycle_cnt=2 after clk 12.
REQ-030 branch_req=1 during Q4 of the 2nd RUN cycle -> the next cycle has exec_valid=0 and cycle_cnt does not increment; the following cycle has exec_valid=1.
REQ-031 halt_req=1 asserted at Q2 and held 10 clk -> the current cycle completes, strobes go to 0 and state=3; after halt_req=0, q1 appears on the next edge.
REQ-032 branch_req and halt_req both 1 at the same Q4 -> HALT; after release, the first cycle has exec_valid=0.
REQ-033 With CNT_W=2, run 5 valid cycles -> cycle_cnt sequence 1,2,3,0,1.
REQ-034 Reset asserted at Q3 -> all outputs 0 asynchronously, before the next edge; with CYCLE_SEQ_STEP_EN, one step pulse in HALT -> exactly 4 strobe clk cycles, then HALT.

Source files
------------

// File: rtl/cycle_seq_pkg.sv
// Shared types for the instruction-cycle sequencer: FSM states, quadrature phases
// and the 2-bit state encoding presented on the state output.
package cycle_seq_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_FILL,
    ST_RUN,
    ST_FLUSH,
    ST_HALT
  } state_e;

  typedef enum logic [1:0] {
    PH_Q1 = 2'd0,
    PH_Q2 = 2'd1,
    PH_Q3 = 2'd2,
    PH_Q4 = 2'd3
  } phase_e;

  localparam logic [1:0] STATE_OUT_IDLE = 2'd0;
  localparam logic [1:0] STATE_OUT_FILL = 2'd1;
  localparam logic [1:0] STATE_OUT_RUN  = 2'd2;
  localparam logic [1:0] STATE_OUT_HALT = 2'd3;

  // FLUSH is externally indistinguishable from RUN apart from exec_valid.
  function automatic logic [1:0] state_out(input state_e st);
    logic [1:0] enc;
    enc = STATE_OUT_IDLE;
    unique case (st)
      ST_IDLE:  enc = STATE_OUT_IDLE;
      ST_FILL:  enc = STATE_OUT_FILL;
      ST_RUN:   enc = STATE_OUT_RUN;
      ST_FLUSH: enc = STATE_OUT_RUN;
      ST_HALT:  enc = STATE_OUT_HALT;
      default:  enc = STATE_OUT_IDLE;
    endcase
    return enc;
  endfunction

endpackage

// File: rtl/cycle_seq_phase_gen.sv
// Quadrature phase counter with registered one-hot strobes (bit i = phase Qi+1).
// adv steps the counter; strobe_en decides whether the next cycle shows a strobe.
module phase_gen
  import cycle_seq_pkg::*;
(
  input  logic       clk,
  input  logic       reset,
  input  logic       adv,
  input  logic       strobe_en,
  output logic [1:0] phase,
  output logic [3:0] strobe
);

  logic [1:0] phase_q, phase_d;
  logic [3:0] strobe_q, strobe_d;
  logic [3:0] one_hot_base;

  always_comb begin
    one_hot_base = 4'b0001;
    phase_d      = phase_q;
    if (adv) begin
      phase_d = phase_q + 2'd1;
    end
    strobe_d = strobe_en ? (one_hot_base << phase_d) : 4'b0000;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      phase_q  <= PH_Q1;
      strobe_q <= 4'b0000;
    end else begin
      phase_q  <= phase_d;
      strobe_q <= strobe_d;
    end
  end

  assign phase  = phase_q;
  assign strobe = strobe_q;

endmodule

// File: rtl/cycle_seq.sv
// Four-phase instruction-cycle sequencer with fill/flush/halt control.
// Define CYCLE_SEQ_STEP_EN to add a single-step input usable while halted.
module cycle_seq
  import cycle_seq_pkg::*;
#(
  parameter int CNT_W = 8
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             branch_req,
  input  logic             halt_req,
`ifdef CYCLE_SEQ_STEP_EN
  input  logic             step,
`endif
  output logic             q1,
  output logic             q2,
  output logic             q3,
  output logic             q4,
  output logic             fetch_en,
  output logic             pc_inc,
  output logic             exec_valid,
  output logic [1:0]       state,
  output logic [CNT_W-1:0] cycle_cnt
);

  state_e           state_q, state_d;
  logic             flush_pend_q, flush_pend_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             adv;
  logic             strobe_en;
  logic             branch_take;
  logic             stop_req;
  logic             resume_go;
  logic [1:0]       phase;
  logic [3:0]       strobe;
`ifdef CYCLE_SEQ_STEP_EN
  logic             step_run_q, step_run_d;
`endif

  phase_gen u_phase_gen (
    .clk       (clk),
    .reset     (reset),
    .adv       (adv),
    .strobe_en (strobe_en),
    .phase     (phase),
    .strobe    (strobe)
  );

  // A stepped cycle always falls back into HALT, whatever halt_req says.
  always_comb begin
`ifdef CYCLE_SEQ_STEP_EN
    stop_req  = halt_req || step_run_q;
    resume_go = step || !halt_req;
`else
    stop_req  = halt_req;
    resume_go = !halt_req;
`endif
  end

  always_comb begin
    state_d      = state_q;
    flush_pend_d = flush_pend_q;
    cnt_d        = cnt_q;
    adv          = 1'b0;
    strobe_en    = 1'b0;
    branch_take  = 1'b0;
`ifdef CYCLE_SEQ_STEP_EN
    step_run_d   = step_run_q;
`endif
    unique case (state_q)
      ST_IDLE: begin
        state_d   = ST_FILL;
        strobe_en = 1'b1;
      end
      ST_FILL, ST_RUN, ST_FLUSH: begin
        adv       = 1'b1;
        strobe_en = 1'b1;
        if (phase == PH_Q4) begin
          branch_take = (state_q == ST_RUN) && branch_req;
          if (state_q == ST_RUN) begin
            cnt_d = cnt_q + 1'b1;
          end
          if (stop_req) begin
            state_d      = ST_HALT;
            strobe_en    = 1'b0;
            flush_pend_d = branch_take;
`ifdef CYCLE_SEQ_STEP_EN
            step_run_d   = 1'b0;
`endif
          end else begin
            state_d = branch_take ? ST_FLUSH : ST_RUN;
          end
        end
      end
      ST_HALT: begin
        // The pipeline is still full on exit, so resume straight into RUN
        // unless a branch was taken on the way into HALT.
        if (resume_go) begin
          state_d      = flush_pend_q ? ST_FLUSH : ST_RUN;
          flush_pend_d = 1'b0;
          strobe_en    = 1'b1;
`ifdef CYCLE_SEQ_STEP_EN
          step_run_d   = step;
`endif
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q      <= ST_IDLE;
      flush_pend_q <= 1'b0;
      cnt_q        <= '0;
`ifdef CYCLE_SEQ_STEP_EN
      step_run_q   <= 1'b0;
`endif
    end else begin
      state_q      <= state_d;
      flush_pend_q <= flush_pend_d;
      cnt_q        <= cnt_d;
`ifdef CYCLE_SEQ_STEP_EN
      step_run_q   <= step_run_d;
`endif
    end
  end

  assign q1         = strobe[0];
  assign q2         = strobe[1];
  assign q3         = strobe[2];
  assign q4         = strobe[3];
  assign fetch_en   = strobe[3];
  assign pc_inc     = strobe[0];
  assign exec_valid = (state_q == ST_RUN);
  assign state      = state_out(state_q);
  assign cycle_cnt  = cnt_q;

endmodule

// File: tb/tb_cycle_seq.sv
// Directed bench for cycle_seq: a default-width instance plus a CNT_W=2 instance
// driven by the same stimulus, checked with immediate assertions.
module tb_cycle_seq;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       branch_req = 1'b0;
  logic       halt_req = 1'b0;
`ifdef CYCLE_SEQ_STEP_EN
  logic       step = 1'b0;
`endif

  logic       q1, q2, q3, q4, fetch_en, pc_inc, exec_valid;
  logic [1:0] state;
  logic [7:0] cycle_cnt;

  logic       q1_s, q2_s, q3_s, q4_s, fetch_en_s, pc_inc_s, exec_valid_s;
  logic [1:0] state_s;
  logic [1:0] cycle_cnt_s;

  int compared   = 0;
  int mismatched = 0;

  always #5 clk = ~clk;

  cycle_seq #(.CNT_W(8)) dut (
    .clk        (clk),
    .reset      (reset),
    .branch_req (branch_req),
    .halt_req   (halt_req),
`ifdef CYCLE_SEQ_STEP_EN
    .step       (step),
`endif
    .q1         (q1),
    .q2         (q2),
    .q3         (q3),
    .q4         (q4),
    .fetch_en   (fetch_en),
    .pc_inc     (pc_inc),
    .exec_valid (exec_valid),
    .state      (state),
    .cycle_cnt  (cycle_cnt)
  );

  cycle_seq #(.CNT_W(2)) dut_small (
    .clk        (clk),
    .reset      (reset),
    .branch_req (branch_req),
    .halt_req   (halt_req),
`ifdef CYCLE_SEQ_STEP_EN
    .step       (step),
`endif
    .q1         (q1_s),
    .q2         (q2_s),
    .q3         (q3_s),
    .q4         (q4_s),
    .fetch_en   (fetch_en_s),
    .pc_inc     (pc_inc_s),
    .exec_valid (exec_valid_s),
    .state      (state_s),
    .cycle_cnt  (cycle_cnt_s)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    compared++;
    assert (obs === exp) else begin
      mismatched++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // stb is {q1,q2,q3,q4}; fetch_en must follow q4 and pc_inc must follow q1.
  task automatic chk_out(input string tag, input logic [1:0] st, input logic [3:0] stb,
                         input logic ev, input logic [7:0] cnt, input logic [1:0] cnt2);
    check({tag, "/outs"},
          {23'd0, state, q1, q2, q3, q4, fetch_en, pc_inc, exec_valid},
          {23'd0, st, stb, stb[0], stb[3], ev});
    check({tag, "/cnt"}, {24'd0, cycle_cnt}, {24'd0, cnt});
    check({tag, "/cnt_w2"}, {30'd0, cycle_cnt_s}, {30'd0, cnt2});
    $display("tick %-10s state=%0d q=%b%b%b%b ev=%b cnt=%0d cnt_w2=%0d",
             tag, state, q1, q2, q3, q4, exec_valid, cycle_cnt, cycle_cnt_s);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
`ifdef CYCLE_SEQ_STEP_EN
    step = 1'b0;
`endif
  endtask

  task automatic chk_cycle(input string tag, input logic [1:0] st, input logic ev,
                           input logic [7:0] cnt, input logic [1:0] cnt2);
    logic [3:0] first;
    first = 4'b1000;
    for (int p = 0; p < 4; p++) begin
      tick();
      chk_out(tag, st, first >> p, ev, cnt, cnt2);
    end
  endtask

  task automatic chk_halt(input string tag, input int n, input logic [7:0] cnt,
                          input logic [1:0] cnt2);
    for (int i = 0; i < n; i++) begin
      tick();
      chk_out(tag, 2'd3, 4'b0000, 1'b0, cnt, cnt2);
    end
  endtask

  initial begin
    // Reset held across the first edge, released between edges.
    #8;
    chk_out("reset", 2'd0, 4'b0000, 1'b0, 8'd0, 2'd0);
    #4 reset = 1'b0;

    // Free run: FILL then RUN, counter steps at each RUN cycle boundary.
    chk_cycle("fill", 2'd1, 1'b0, 8'd0, 2'd0);
    chk_cycle("runA", 2'd2, 1'b1, 8'd0, 2'd0);
    chk_cycle("runB", 2'd2, 1'b1, 8'd1, 2'd1);

    // Branch at Q4 of the second RUN cycle; held through FLUSH Q4 (ignored there).
    branch_req = 1'b1;
    chk_cycle("flush", 2'd2, 1'b0, 8'd2, 2'd2);
    branch_req = 1'b0;
    chk_cycle("runC", 2'd2, 1'b1, 8'd2, 2'd2);
    chk_cycle("runD", 2'd2, 1'b1, 8'd3, 2'd3);

    // Halt requested at Q2 and held 10 clk; the cycle completes first.
    tick();
    chk_out("runE_q1", 2'd2, 4'b1000, 1'b1, 8'd4, 2'd0);
    tick();
    chk_out("runE_q2", 2'd2, 4'b0100, 1'b1, 8'd4, 2'd0);
    halt_req = 1'b1;
    tick();
    chk_out("runE_q3", 2'd2, 4'b0010, 1'b1, 8'd4, 2'd0);
    tick();
    chk_out("runE_q4", 2'd2, 4'b0001, 1'b1, 8'd4, 2'd0);
    chk_halt("halt", 8, 8'd5, 2'd1);
    halt_req = 1'b0;
    chk_cycle("resume", 2'd2, 1'b1, 8'd5, 2'd1);

    // Branch and halt together: HALT first, then a FLUSH cycle on exit.
    branch_req = 1'b1;
    halt_req   = 1'b1;
    chk_halt("bh_halt", 3, 8'd6, 2'd2);
    branch_req = 1'b0;
    halt_req   = 1'b0;
    chk_cycle("bh_flush", 2'd2, 1'b0, 8'd6, 2'd2);
    chk_cycle("runG", 2'd2, 1'b1, 8'd6, 2'd2);

    // Asynchronous reset at Q3, observed before the next edge.
    tick();
    chk_out("runH_q1", 2'd2, 4'b1000, 1'b1, 8'd7, 2'd3);
    tick();
    chk_out("runH_q2", 2'd2, 4'b0100, 1'b1, 8'd7, 2'd3);
    tick();
    chk_out("runH_q3", 2'd2, 4'b0010, 1'b1, 8'd7, 2'd3);
    #2 reset = 1'b1;
    #1;
    chk_out("async_rst", 2'd0, 4'b0000, 1'b0, 8'd0, 2'd0);
    tick();
    chk_out("rst_held", 2'd0, 4'b0000, 1'b0, 8'd0, 2'd0);
    #2 reset = 1'b0;
    chk_cycle("refill", 2'd1, 1'b0, 8'd0, 2'd0);

`ifdef CYCLE_SEQ_STEP_EN
    // Single step from HALT with halt_req still high.
    halt_req = 1'b1;
    chk_halt("pre_step", 2, 8'd0, 2'd0);
    step = 1'b1;
    chk_cycle("step", 2'd2, 1'b1, 8'd0, 2'd0);
    chk_halt("post_step", 3, 8'd1, 2'd1);
    halt_req = 1'b0;
`else
    chk_cycle("rerun", 2'd2, 1'b1, 8'd0, 2'd0);
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
